mul8u_dot_acc: RTL
==================

// Module: mul8u_dot_acc
// PURPOSE
//  Downstream consumer of the 8x8 unsigned (approximate) multiplier. Accepts one 16-bit
//  product per cycle over valid/ready and accumulates LEN products into one dot-product sum.
//  Each finished sum is presented over a registered valid/ready output with a saturation flag.
//  Sits between the combinational multiplier array and the result writeback/FIFO.
// PARAMETERS
//  LEN    16  products per dot product, >=2
//  ACC_W  20  accumulator/result width, >=16; LEN=16 x 65535 needs 20 bits for no overflow
//  CNT_W  $clog2(LEN)  element counter width, derived, not overridden
// PORTS
//  clk          in   1      rising-edge clock, single domain
//  rst_n        in   1      asynchronous, active-low reset
//  clr_i        in   1      synchronous flush of the partial accumulation
//  prod_i       in   16     product from the multiplier, O[15:0]
//  prod_valid_i in   1      prod_i valid
//  prod_ready_o out  1      block can accept prod_i this cycle
//  sum_o        out  ACC_W  completed dot-product sum
//  sum_ovf_o    out  1      sum_o saturated; qualified by sum_valid_o
//  sum_valid_o  out  1      sum_o/sum_ovf_o valid
//  sum_ready_i  in   1      downstream accepts sum_o
//  cnt_o        out  CNT_W  products accumulated in the current group
// BEHAVIOUR
//  Reset: acc=0, cnt_o=0, sum_o=0, sum_ovf_o=0, sum_valid_o=0, internal ovf=0.
//   prod_ready_o is derived combinationally from registered state.
//  Product accept: prod_valid_i & prod_ready_o.
//  Input transfer: no effect unless accepted; prod_i may change freely while not accepted.
//  Accumulate: acc_next = sat(acc + zero_ext(prod_i)).
//   - Saturate to 2^ACC_W-1 on carry out.
//   - Sticky ovf bit per group.
//  States:
//   ACCUM: cnt < LEN-1. On accept: add the product, cnt+1.
//   LAST:  cnt == LEN-1. On accept, on the same edge:
//    - sum_o <= acc_next, sum_ovf_o <= ovf | carry, sum_valid_o <= 1;
//    - acc, cnt, ovf <= 0;
//    - state -> ACCUM.
//  Output transfer: sum_valid_o & sum_ready_i.
//   - With no new completion that cycle, sum_valid_o <= 0.
//   - sum_o and sum_ovf_o hold their value while valid and not accepted.
//  Latency: last product accepted at edge t -> sum_valid_o high after edge t.
//   No bubble between groups.
//  Backpressure: prod_ready_o = !clr_i & !(cnt==LEN-1 & sum_valid_o & !sum_ready_i).
//   - Only the completing product stalls; partial products keep flowing.
//  Simultaneous output transfer and new completion: the new sum is loaded and
//   sum_valid_o stays 1 (back-to-back results).
//  clr_i: acc, cnt, ovf <= 0 and prod_ready_o=0 that cycle, so no product is lost.
//   - Pending sum_o/sum_valid_o are untouched.
//   - Any output transfer still completes.
//  Wrap-around: cnt returns to 0 after LEN accepts. No other wrap exists; acc never wraps.
//  Reset mid-group or mid-output: all state cleared immediately, and the partial group
//   and pending sum are discarded.
//  LEN=1 is illegal; elaboration fails via a generate-time check.
// STRUCTURE
//  Package mul8u_acc_pkg:
//   - state enum {ACCUM, LAST};
//   - PROD_W=16;
//   - function sat_add(acc, prod) returning {carry, sum}.
//  Sub-module mul8u_sat_add: parameterised ACC_W saturating adder, combinational.
//   Reused by the multiplier bias-compensation stage.
//  Top level: counter + FSM, accumulator register, single-entry output register.
// TESTING
//  1 Reset: hold rst_n=0 with prod_valid_i=1.
//    -> all outputs 0, prod_ready_o=1 after release.
//  2 LEN=4: feed prod_i = 1,2,3,4 on consecutive cycles, sum_ready_i=1.
//    -> sum_o=10, sum_ovf_o=0, sum_valid_o for exactly 1 cycle, 1 cycle after the 4th accept.
//  3 Back-to-back groups: LEN=2, stream 100,200,300,400 continuously.
//    -> sums 300 then 700 on consecutive valid cycles, prod_ready_o never low.
//  4 Backpressure: LEN=2, sum_ready_i=0, stream 5,6,7,8.
//    -> sum_o=11 held; 7 accepted; prod_ready_o=0 while 8 is offered;
//    -> sum_ready_i=1 releases 8 and loads sum_o=15.
//  5 Saturation: ACC_W=16, LEN=2, products 65025,65025.
//    -> sum_o=65535, sum_ovf_o=1; next group 1,1 -> sum_o=2, sum_ovf_o=0.
//  6 clr_i and reset: LEN=4, accept 9,9, then clr_i with prod_valid_i=1.
//    -> prod_ready_o=0, cnt_o=0; then 1,1,1,1 -> sum_o=4.
//    Assert rst_n=0 mid-group -> no sum is ever emitted for that group.

Source files
------------

// File: rtl/mul8u_acc_pkg.sv
// Shared types and the saturating-add helper for the multiplier dot-product accumulator.
package mul8u_acc_pkg;

  typedef enum logic {ACCUM = 1'b0, LAST = 1'b1} state_e;

  localparam int PROD_W  = 16;
  localparam int ACC_MAX = 32;

  // Returns {carry, sum}; sum is clamped to 2^acc_w-1 when the add exceeds acc_w bits.
  function automatic logic [ACC_MAX:0] sat_add(input logic [ACC_MAX-1:0] acc,
                                                input logic [PROD_W-1:0]  prod,
                                                input int unsigned        acc_w);
    logic [ACC_MAX:0] raw;
    logic [ACC_MAX:0] lim;
    raw = {1'b0, acc} + {{(ACC_MAX + 1 - PROD_W){1'b0}}, prod};
    lim = ({{ACC_MAX{1'b0}}, 1'b1} << acc_w) - {{ACC_MAX{1'b0}}, 1'b1};
    if (raw > lim) sat_add = {1'b1, lim[ACC_MAX-1:0]};
    else           sat_add = {1'b0, raw[ACC_MAX-1:0]};
  endfunction

endpackage

// File: rtl/mul8u_sat_add.sv
// Combinational ACC_W-bit saturating adder of an accumulator and a 16-bit product.
module mul8u_sat_add
  import mul8u_acc_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  logic [ACC_MAX:0] w_res;

  generate
    if (ACC_W < PROD_W || ACC_W > ACC_MAX) begin : g_w_chk
      $error("mul8u_sat_add: ACC_W must be within [16, 32]");
    end
  endgenerate

  assign w_res   = sat_add(ACC_MAX'(i_acc), i_prod, ACC_W);
  assign o_carry = w_res[ACC_MAX];
  assign o_sum   = w_res[ACC_W-1:0];

  generate
    if (ACC_W < ACC_MAX) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = |w_res[ACC_MAX-1:ACC_W];
    end
  endgenerate

endmodule

// File: rtl/mul8u_dot_acc.sv
// Accumulates LEN multiplier products into one saturating dot-product sum, emitted through
// a single-entry registered valid/ready output; only the group-completing product can stall.
module mul8u_dot_acc
  import mul8u_acc_pkg::*;
#(
  parameter  int LEN   = 16,
  parameter  int ACC_W = 20,
  localparam int CNT_W = $clog2(LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              prod_valid_i,
  output logic              prod_ready_o,
  output logic [ACC_W-1:0]  sum_o,
  output logic              sum_ovf_o,
  output logic              sum_valid_o,
  input  logic              sum_ready_i,
  output logic [CNT_W-1:0]  cnt_o
);

  generate
    if (LEN < 2) begin : g_len_chk
      $error("mul8u_dot_acc: LEN must be at least 2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(LEN - 2);

  state_e           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_sum;
  logic             r_sum_ovf;
  logic             r_sum_vld;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_carry;
  logic             w_accept;

  mul8u_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .i_acc   (r_acc),
    .i_prod  (prod_i),
    .o_sum   (w_acc_nxt),
    .o_carry (w_carry)
  );

  // The output register is single-entry, so only a completion into a stuck result must wait.
  assign prod_ready_o = !clr_i && !(r_state == LAST && r_sum_vld && !sum_ready_i);
  assign w_accept     = prod_valid_i && prod_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_sum_ovf <= 1'b0;
      r_sum_vld <= 1'b0;
    end else begin
      if (r_sum_vld && sum_ready_i) r_sum_vld <= 1'b0;
      if (clr_i) begin
        r_state <= ACCUM;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end else if (w_accept) begin
        if (r_state == LAST) begin
          r_sum     <= w_acc_nxt;
          r_sum_ovf <= r_ovf | w_carry;
          r_sum_vld <= 1'b1;
          r_state   <= ACCUM;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_ovf     <= 1'b0;
        end else begin
          r_acc   <= w_acc_nxt;
          r_ovf   <= r_ovf | w_carry;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == CNT_PRELAST) ? LAST : ACCUM;
        end
      end
    end
  end

  assign sum_o       = r_sum;
  assign sum_ovf_o   = r_sum_ovf;
  assign sum_valid_o = r_sum_vld;
  assign cnt_o       = r_cnt;

endmodule
